// File: rtl/monitor_rpt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : monitor_rpt_pkg
//  Purpose  : Shared constants, entry record and drain-FSM state encoding
//             for the LTL monitor report arbiter.
//  Contents : NUM_REPORTS_DEF, IDX_W_DEF, RPT_ID_W, rpt_entry_t, drain_state_t
//  Revision : 1.0  initial release
// ============================================================================
package monitor_rpt_pkg;

    localparam int NUM_REPORTS_DEF = 28;
    localparam int IDX_W_DEF       = 32;
    localparam int RPT_ID_W        = $clog2(NUM_REPORTS_DEF);

    // Buffered record for the default configuration: report vector + symbol tag.
    typedef struct packed {
        logic [NUM_REPORTS_DEF-1:0] vec;
        logic [IDX_W_DEF-1:0]       idx;
    } rpt_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } drain_state_t;

endpackage : monitor_rpt_pkg
`default_nettype wire

// File: rtl/monitor_rpt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : monitor_rpt_fifo
//  Purpose  : Synchronous FIFO with occupancy count. A push into a full FIFO
//             is accepted only when a pop happens in the same cycle; a pop
//             from an empty FIFO is ignored.
//  Ports    : clk, reset (sync, active high)
//             push_i/wdata_i   write request and data
//             pop_i            read request (head is rdata_o)
//             rdata_o          head entry (valid when !empty_o)
//             count_o          entries held, 0..DEPTH
//             empty_o/full_o   occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module monitor_rpt_fifo #(
    parameter  int WIDTH = 60,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             w_wr_en;
    logic             w_rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign w_rd_en = pop_i && !empty_o;
    // Room is freed by a same-cycle pop, so a full FIFO can still take a write.
    assign w_wr_en = push_i && (!full_o || w_rd_en);

    always_comb begin
        count_d = count_q;
        case ({w_wr_en, w_rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule : monitor_rpt_fifo
`default_nettype wire

// File: rtl/monitor_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : monitor_report_arbiter
//  Purpose  : Captures non-zero per-symbol report vectors from the LTL monitor
//             stages, tags them with the symbol index, buffers them and drains
//             one (id, index) record per handshake, lowest bit first.
//  Ports    : clk, reset (sync, active high)
//             run, reports_in         symbol strobe and report vector
//             stall                   advisory back-pressure (count >= DEPTH-1)
//             rpt_valid/rpt_ready     record handshake
//             rpt_id, rpt_index       record payload
//             overflow                sticky drop flag
//             drop_cnt                saturating drop counter (optional)
//  Config   : define MONITOR_RPT_DROP_CNT_EN to add the drop_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module monitor_report_arbiter
    import monitor_rpt_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic [NUM_REPORTS-1:0]         reports_in,
    output logic                           stall,
    output logic                           rpt_valid,
    input  logic                           rpt_ready,
    output logic [$clog2(NUM_REPORTS)-1:0] rpt_id,
    output logic [IDX_W-1:0]               rpt_index,
`ifdef MONITOR_RPT_DROP_CNT_EN
    output logic [15:0]                    drop_cnt,
`endif
    output logic                           overflow
);

    localparam int ID_W  = $clog2(NUM_REPORTS);
    localparam int ENT_W = NUM_REPORTS + IDX_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t           state_q, state_d;
    logic [NUM_REPORTS-1:0] wvec_q, wvec_d;
    logic [IDX_W-1:0]       widx_q, widx_d;
    logic [IDX_W-1:0]       sym_idx_q;
    logic                   overflow_q;

    logic                   w_capture;
    logic                   w_pop;
    logic                   w_drop;
    logic [ENT_W-1:0]       w_head;
    logic [NUM_REPORTS-1:0] w_head_vec;
    logic [IDX_W-1:0]       w_head_idx;
    logic [CNT_W-1:0]       w_count;
    logic                   w_empty;
    logic                   w_full;
    logic [ID_W-1:0]        w_low_id;
    logic [NUM_REPORTS-1:0] w_vec_clr;

    assign w_capture = run && (reports_in != '0);
    // Mirrors the FIFO's acceptance rule so the drop is flagged on the same edge.
    assign w_drop    = w_capture && w_full && !w_pop;

    monitor_rpt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_capture),
        .wdata_i ({reports_in, sym_idx_q}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign w_head_vec = w_head[ENT_W-1 -: NUM_REPORTS];
    assign w_head_idx = w_head[IDX_W-1:0];

    // Lowest-set-bit encoder: scanning downward leaves the lowest hit last.
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
            if (wvec_q[i]) w_low_id = ID_W'(i);
        end
    end

    assign w_vec_clr = wvec_q & ~(NUM_REPORTS'(1) << w_low_id);

    always_comb begin
        state_d   = state_q;
        wvec_d    = wvec_q;
        widx_d    = widx_q;
        w_pop     = 1'b0;
        rpt_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    wvec_d  = w_head_vec;
                    widx_d  = w_head_idx;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                rpt_valid = 1'b1;
                if (rpt_ready) begin
                    wvec_d = w_vec_clr;
                    if (w_vec_clr == '0) begin
                        // Last bit of this vector: chain straight into the next one.
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            wvec_d = w_head_vec;
                            widx_d = w_head_idx;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wvec_q     <= '0;
            widx_q     <= '0;
            sym_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wvec_q  <= wvec_d;
            widx_q  <= widx_d;
            if (run)    sym_idx_q  <= sym_idx_q + IDX_W'(1);
            if (w_drop) overflow_q <= 1'b1;
        end
    end

`ifdef MONITOR_RPT_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign stall     = (w_count >= CNT_W'(FIFO_DEPTH - 1));
    assign rpt_id    = w_low_id;
    assign rpt_index = widx_q;
    assign overflow  = overflow_q;

endmodule : monitor_report_arbiter
`default_nettype wire

// File: tb/tb_monitor_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_monitor_report_arbiter
//  Purpose  : Self-checking bench for monitor_report_arbiter. Two instances
//             share all inputs: one with the default 32-bit index, one with
//             a 4-bit index to exercise tag wrap-around. Expected records are
//             built from the capture rules (one record per set bit, ascending,
//             in capture order, tagged with the running symbol count).
//  Config   : MONITOR_RPT_DROP_CNT_EN adds drop_cnt checks.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_monitor_report_arbiter;

    localparam int NR = 28;
    localparam int IW = 32;

    typedef struct {
        int          id;
        logic [31:0] idx;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] idx;
        logic [3:0]  idx4;
        int          cyc;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          rpt_ready;
    logic [NR-1:0] reports_in;

    logic          stall_a, valid_a, ovf_a;
    logic [4:0]    id_a;
    logic [IW-1:0] idx_a;
    logic          stall_b, valid_b, ovf_b;
    logic [4:0]    id_b;
    logic [3:0]    idx_b;
`ifdef MONITOR_RPT_DROP_CNT_EN
    logic [15:0]   dcnt_a, dcnt_b;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          stab_viol = 0;
    int          pair_viol = 0;
    int          first_valid_cyc = -1;
    logic [31:0] sym = '0;
    exp_t        expq[$];
    rec_t        obs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    monitor_report_arbiter #(.NUM_REPORTS(NR), .IDX_W(IW), .FIFO_DEPTH(8)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .reports_in (reports_in),
        .stall      (stall_a),
        .rpt_valid  (valid_a),
        .rpt_ready  (rpt_ready),
        .rpt_id     (id_a),
        .rpt_index  (idx_a),
`ifdef MONITOR_RPT_DROP_CNT_EN
        .drop_cnt   (dcnt_a),
`endif
        .overflow   (ovf_a)
    );

    monitor_report_arbiter #(.NUM_REPORTS(NR), .IDX_W(4), .FIFO_DEPTH(8)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .reports_in (reports_in),
        .stall      (stall_b),
        .rpt_valid  (valid_b),
        .rpt_ready  (rpt_ready),
        .rpt_id     (id_b),
        .rpt_index  (idx_b),
`ifdef MONITOR_RPT_DROP_CNT_EN
        .drop_cnt   (dcnt_b),
`endif
        .overflow   (ovf_b)
    );

    // Observer: logs handshakes, checks hold stability and instance agreement.
    logic        prev_hold = 1'b0;
    logic        prev_valid = 1'b0;
    logic [4:0]  hold_id;
    logic [31:0] hold_idx;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (valid_a && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_hold && (!valid_a || id_a !== hold_id || idx_a !== hold_idx)) stab_viol++;
            if (valid_b !== valid_a || id_b !== id_a || stall_b !== stall_a || ovf_b !== ovf_a) pair_viol++;
`ifdef MONITOR_RPT_DROP_CNT_EN
            if (dcnt_b !== dcnt_a) pair_viol++;
`endif
            if (valid_a && rpt_ready) obs.push_back('{int'(id_a), idx_a, idx_b, cyc});
            prev_hold  = valid_a && !rpt_ready;
            hold_id    = id_a;
            hold_idx   = idx_a;
            prev_valid = valid_a;
        end
    end

    // One input cycle; expected records are appended when the vector is accepted.
    task automatic drive(input bit r, input logic [NR-1:0] v, input bit rdy, input bit accept);
        @(posedge clk); #1;
        run        = r;
        reports_in = v;
        rpt_ready  = rdy;
        if (r) begin
            if (v != '0 && accept) begin
                for (int b = 0; b < NR; b++) if (v[b]) expq.push_back('{b, sym});
            end
            sym = sym + 32'd1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; run = 1'b0; reports_in = '0; rpt_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete(); obs.delete();
        sym = '0; first_valid_cyc = -1;
    endtask

    task automatic wait_drain(input bit rand_rdy, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            drive(1'b0, '0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
            if (obs.size() == expq.size() && !valid_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; reports_in = '0; rpt_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_a); end
        total++; if (id_a !== 5'd0 || idx_a !== 32'd0) begin bad++; $display("FAIL reset_payload got id=%0d idx=%0d want 0/0", id_a, idx_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", ovf_a); end
`ifdef MONITOR_RPT_DROP_CNT_EN
        total++; if (dcnt_a !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got %0d want 0", dcnt_a); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete(); obs.delete(); sym = '0; first_valid_cyc = -1;
    endtask

    task automatic test_basic();
        bit ok;
        int cap_cyc;
        do_reset();
        repeat (3) drive(1'b1, '0, 1'b1, 1'b1);
        drive(1'b1, (NR'(1) << 5) | (NR'(1) << 17), 1'b1, 1'b1);
        cap_cyc = cyc;
        wait_drain(1'b0, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_drain timeout obs=%0d exp=%0d", obs.size(), expq.size()); end
        total++; if (obs.size() != 2) begin bad++; $display("FAIL basic_count got %0d want 2", obs.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].id !== expq[i].id || obs[i].idx !== expq[i].idx || obs[i].idx4 !== expq[i].idx[3:0]) begin
                bad++; $display("FAIL basic_rec[%0d] got id=%0d idx=%0d want id=%0d idx=%0d", i, obs[i].id, obs[i].idx, expq[i].id, expq[i].idx);
            end
        end
        if (obs.size() == 2) begin
            total++; if (obs[0].id !== 5 || obs[0].idx !== 32'd3 || obs[1].id !== 17 || obs[1].idx !== 32'd3) begin
                bad++; $display("FAIL basic_values got (%0d,%0d)(%0d,%0d) want (5,3)(17,3)", obs[0].id, obs[0].idx, obs[1].id, obs[1].idx);
            end
        end
        total++; if (first_valid_cyc !== cap_cyc + 2) begin bad++; $display("FAIL basic_latency got cycle %0d want %0d", first_valid_cyc, cap_cyc + 2); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        drive(1'b1, NR'(1), 1'b1, 1'b1);
        drive(1'b1, NR'(1) << 27, 1'b1, 1'b1);
        wait_drain(1'b0, 50, ok);
        total++; if (!ok || obs.size() != 2) begin bad++; $display("FAIL b2b_count got %0d want 2", obs.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].id !== expq[i].id || obs[i].idx !== expq[i].idx) begin
                bad++; $display("FAIL b2b_rec[%0d] got id=%0d idx=%0d want id=%0d idx=%0d", i, obs[i].id, obs[i].idx, expq[i].id, expq[i].idx);
            end
        end
        if (obs.size() == 2) begin
            total++; if (obs[1].cyc !== obs[0].cyc + 1) begin bad++; $display("FAIL b2b_gap got cycles %0d,%0d want consecutive", obs[0].cyc, obs[1].cyc); end
        end
    endtask

    // With ready low, the first vector moves into the drain registers, so the
    // FIFO fills with vectors 1..8; vector 9 (the tenth) is the one dropped.
    // FIFO count in the cycle vector i is presented is i-1 (i>=2), hence stall
    // first reads 1 when vector 8 is presented.
    task automatic test_overflow();
        bit ok;
        logic [NR-1:0] v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = (NR'(1) << i) | (NR'(1) << (27 - i));
            drive(1'b1, v, 1'b0, i < 9);
            @(negedge clk);
            total++; if (stall_a !== (i >= 8)) begin bad++; $display("FAIL ovf_stall[%0d] got %b want %b", i, stall_a, (i >= 8)); end
            if (i == 9) begin
                total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_early got %b want 0", ovf_a); end
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", ovf_a); end
        total++; if (valid_a !== 1'b1 || obs.size() != 0) begin bad++; $display("FAIL ovf_hold valid=%b obs=%0d want 1/0", valid_a, obs.size()); end
`ifdef MONITOR_RPT_DROP_CNT_EN
        total++; if (dcnt_a !== 16'd1) begin bad++; $display("FAIL ovf_drop_cnt got %0d want 1", dcnt_a); end
`endif
        wait_drain(1'b0, 100, ok);
        total++; if (!ok || obs.size() != 18) begin bad++; $display("FAIL ovf_count got %0d want 18", obs.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].id !== expq[i].id || obs[i].idx !== expq[i].idx) begin
                bad++; $display("FAIL ovf_rec[%0d] got id=%0d idx=%0d want id=%0d idx=%0d", i, obs[i].id, obs[i].idx, expq[i].id, expq[i].idx);
            end
        end
        total++; if (ovf_a !== 1'b1 || stall_a !== 1'b0) begin bad++; $display("FAIL ovf_after ovf=%b stall=%b want 1/0", ovf_a, stall_a); end
    endtask

    task automatic test_random_ready();
        bit ok;
        logic [NR-1:0] v;
        do_reset();
        drive(1'b1, NR'(32'h0FFF_FFFF), 1'($urandom_range(0, 1)), 1'b1);
        wait_drain(1'b1, 400, ok);
        total++; if (!ok || obs.size() != 28) begin bad++; $display("FAIL rnd_full_count got %0d want 28", obs.size()); end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].id !== i || obs[i].idx !== 32'd0) begin
                bad++; $display("FAIL rnd_full_rec[%0d] got id=%0d idx=%0d want id=%0d idx=0", i, obs[i].id, obs[i].idx, i);
            end
        end
        // Random bursts of at most six symbols can never exceed FIFO + drain capacity.
        for (int round = 0; round < 8; round++) begin
            for (int j = 0; j < 6; j++) begin
                v = NR'($urandom);
                if ($urandom_range(0, 3) == 0) v = '0;
                drive(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), 1'b1);
            end
            wait_drain(1'b1, 600, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd_drain[%0d] timeout obs=%0d exp=%0d", round, obs.size(), expq.size()); end
        end
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL rnd_count got %0d want %0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].id !== expq[i].id || obs[i].idx !== expq[i].idx || obs[i].idx4 !== expq[i].idx[3:0]) begin
                bad++; $display("FAIL rnd_rec[%0d] got id=%0d idx=%0d want id=%0d idx=%0d", i, obs[i].id, obs[i].idx, expq[i].id, expq[i].idx);
            end
        end
        total++; if (stab_viol !== 0) begin bad++; $display("FAIL rnd_stability got %0d violations want 0", stab_viol); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL rnd_overflow got %b want 0", ovf_a); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, NR'(1) << (i + 1), 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL rmid_emit got valid=%b want 1", valid_a); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete(); obs.delete(); sym = '0;
        @(negedge clk);
        total++; if (valid_a !== 1'b0 || stall_a !== 1'b0) begin bad++; $display("FAIL rmid_cleared valid=%b stall=%b want 0/0", valid_a, stall_a); end
        repeat (15) drive(1'b0, '0, 1'b1, 1'b1);
        total++; if (obs.size() != 0) begin bad++; $display("FAIL rmid_stale got %0d records want 0", obs.size()); end
        drive(1'b1, NR'(1) << 9, 1'b1, 1'b1);
        wait_drain(1'b0, 50, ok);
        total++; if (!ok || obs.size() != 1) begin bad++; $display("FAIL rmid_new_count got %0d want 1", obs.size()); end
        else if (obs[0].id !== 9 || obs[0].idx !== 32'd0) begin
            bad++; $display("FAIL rmid_new_rec got id=%0d idx=%0d want id=9 idx=0", obs[0].id, obs[0].idx);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        repeat (17) drive(1'b1, NR'(1) << 3, 1'b1, 1'b1);
        wait_drain(1'b0, 80, ok);
        total++; if (!ok || obs.size() != 17) begin bad++; $display("FAIL wrap_count got %0d want 17", obs.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].id !== 3 || obs[i].idx !== expq[i].idx || obs[i].idx4 !== 4'(i % 16)) begin
                bad++; $display("FAIL wrap_rec[%0d] got id=%0d idx=%0d idx4=%0d want id=3 idx=%0d idx4=%0d", i, obs[i].id, obs[i].idx, obs[i].idx4, expq[i].idx, i % 16);
            end
        end
        if (obs.size() == 17) begin
            total++; if (obs[16].idx4 !== 4'd0 || obs[16].idx !== 32'd16) begin
                bad++; $display("FAIL wrap_last got idx4=%0d idx=%0d want 0/16", obs[16].idx4, obs[16].idx);
            end
        end
        total++; if (pair_viol !== 0) begin bad++; $display("FAIL pair_agree got %0d disagreements want 0", pair_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_random_ready();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_monitor_report_arbiter
`default_nettype wire
